// File: rtl/alu_pkg.sv
// Shared constants for the alu_mdu execute unit: operation codes, FSM states and op-class helpers.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLTU  = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_MULT  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_DIV   = 4'b1110;
  localparam logic [3:0] OP_RSVD  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    BUSY = 2'b10,
    DONE = 2'b11
  } state_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == OP_MULTU) || (op == OP_MULT);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: one-bit-per-cycle shift-add multiplier and restoring divider working on operand magnitudes.
// The divider datapath exists only when ALU_MDU_DIV_EN is defined; otherwise divide starts are ignored.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn & v[WIDTH-1]) ? -v : v;
  endfunction

  logic               busy_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   lo_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   opnd_r;
  logic               neg_lo_r;
  logic               start_ok_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] prod_s;
`ifdef ALU_MDU_DIV_EN
  logic               div_r;
  logic               neg_hi_r;
  logic [WIDTH:0]     shl_s;
  logic [WIDTH:0]     trial_s;
`endif

  // Per-iteration arithmetic: add-and-shift for multiply, trial subtract for divide.
  always_comb begin
`ifdef ALU_MDU_DIV_EN
    start_ok_s = start;
    shl_s      = {hi_r, lo_r[WIDTH-1]};
    trial_s    = shl_s - {1'b0, opnd_r};
`else
    start_ok_s = start & ~is_div;
`endif
    mul_sum_s = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
  end

  // Sign fix-up applied combinationally while the result is presented.
  always_comb begin
    if (neg_lo_r) begin
      prod_s = -{hi_r, lo_r};
    end else begin
      prod_s = {hi_r, lo_r};
    end
`ifdef ALU_MDU_DIV_EN
    if (div_r) begin
      lo = neg_lo_r ? -lo_r : lo_r;
      hi = neg_hi_r ? -hi_r : hi_r;
    end else begin
      lo = prod_s[WIDTH-1:0];
      hi = prod_s[2*WIDTH-1:WIDTH];
    end
`else
    lo = prod_s[WIDTH-1:0];
    hi = prod_s[2*WIDTH-1:WIDTH];
`endif
  end

  assign busy = busy_r;
  assign done = busy_r & (cnt_r == CNT_ZERO);

  // Load magnitudes on start, iterate WIDTH times, release once the result has been taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r   <= 1'b0;
      cnt_r    <= CNT_ZERO;
      lo_r     <= ZERO_W;
      hi_r     <= ZERO_W;
      opnd_r   <= ZERO_W;
      neg_lo_r <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      div_r    <= 1'b0;
      neg_hi_r <= 1'b0;
`endif
    end else if (start_ok_s) begin
      busy_r   <= 1'b1;
      cnt_r    <= CNT_INIT;
      hi_r     <= ZERO_W;
      neg_lo_r <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_MDU_DIV_EN
      div_r    <= is_div;
      neg_hi_r <= is_signed & is_div & a[WIDTH-1];
      opnd_r   <= is_div ? mag(b, is_signed) : mag(a, is_signed);
      lo_r     <= is_div ? mag(a, is_signed) : mag(b, is_signed);
`else
      opnd_r   <= mag(a, is_signed);
      lo_r     <= mag(b, is_signed);
`endif
    end else if (busy_r && (cnt_r != CNT_ZERO)) begin
      cnt_r <= cnt_r - CNT_ONE;
`ifdef ALU_MDU_DIV_EN
      if (div_r) begin
        if (!trial_s[WIDTH]) begin
          hi_r <= trial_s[WIDTH-1:0];
          lo_r <= {lo_r[WIDTH-2:0], 1'b1};
        end else begin
          hi_r <= shl_s[WIDTH-1:0];
          lo_r <= {lo_r[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi_r <= mul_sum_s[WIDTH:1];
        lo_r <= {mul_sum_s[0], lo_r[WIDTH-1:1]};
      end
`else
      hi_r <= mul_sum_s[WIDTH:1];
      lo_r <= {mul_sum_s[0], lo_r[WIDTH-1:1]};
`endif
    end else if (busy_r) begin
      busy_r <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: MIPS32 EX-stage ALU plus iterative multiply/divide behind a valid/ready handshake.
// Build option ALU_MDU_DIV_EN: defined builds the restoring divider; undefined makes DIV/DIVU flag div0 in one cycle.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_hi,
  output logic             zero,
  output logic             ovf,
  output logic             div0
);

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};

  state_t             state_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               zero_r;
  logic               ovf_r;
  logic               div0_r;
  logic [WIDTH-1:0]   r_r;
  logic [WIDTH-1:0]   r_hi_r;
  logic [3:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;

  logic               accept_s;
  logic               iter_op_s;
  logic               mdu_start_s;
  logic               mdu_busy_s;
  logic               mdu_done_s;
  logic [WIDTH-1:0]   mdu_lo_s;
  logic [WIDTH-1:0]   mdu_hi_s;
  logic [WIDTH-1:0]   sum_s;
  logic [WIDTH-1:0]   diff_s;
  logic [WIDTH-1:0]   res_s;
  logic [WIDTH-1:0]   res_hi_s;
  logic [SHAMT_W-1:0] shamt_s;
  logic               ovf_s;
  logic               div0_s;
  logic               flags_en_s;
  logic               zero_s;

  // Accept decode: a divide by zero never enters the iterative unit.
  always_comb begin
    accept_s = in_valid & in_ready_r & ~mdu_busy_s;
`ifdef ALU_MDU_DIV_EN
    iter_op_s = is_mul_op(op) | (is_div_op(op) & (b != ZERO_W));
`else
    iter_op_s = is_mul_op(op);
`endif
    mdu_start_s = accept_s & iter_op_s;
  end

  mdu_iter #(
    .WIDTH(WIDTH)
  ) u_mdu (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (mdu_start_s),
    .is_div   (is_div_op(op)),
    .is_signed(is_signed_op(op)),
    .a        (a),
    .b        (b),
    .busy     (mdu_busy_s),
    .done     (mdu_done_s),
    .lo       (mdu_lo_s),
    .hi       (mdu_hi_s)
  );

  // Single-cycle ALU on the operands captured at accept.
  always_comb begin
    sum_s      = a_r + b_r;
    diff_s     = a_r - b_r;
    shamt_s    = b_r[SHAMT_W-1:0];
    res_s      = ZERO_W;
    res_hi_s   = ZERO_W;
    ovf_s      = 1'b0;
    div0_s     = 1'b0;
    flags_en_s = 1'b1;
    case (op_r)
      OP_AND:  res_s = a_r & b_r;
      OP_OR:   res_s = a_r | b_r;
      OP_XOR:  res_s = a_r ^ b_r;
      OP_NOR:  res_s = ~(a_r | b_r);
      OP_ADD: begin
        res_s = sum_s;
        ovf_s = (a_r[WIDTH-1] == b_r[WIDTH-1]) & (sum_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_SUB: begin
        res_s = diff_s;
        ovf_s = (a_r[WIDTH-1] != b_r[WIDTH-1]) & (diff_s[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_SLTU: res_s = {{(WIDTH-1){1'b0}}, (a_r < b_r)};
      OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
      OP_SLL:  res_s = a_r << shamt_s;
      OP_SRL:  res_s = a_r >> shamt_s;
      OP_SRA:  res_s = $unsigned($signed(a_r) >>> shamt_s);
      OP_DIVU, OP_DIV: begin
        // Only divide-by-zero (or a build without the divider) reaches this path.
        div0_s = 1'b1;
`ifdef ALU_MDU_DIV_EN
        res_s    = ONES_W;
        res_hi_s = a_r;
`endif
      end
      default: flags_en_s = 1'b0;
    endcase
    zero_s = flags_en_s & (res_s == ZERO_W);
  end

  // Handshake FSM with registered result and flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      r_r         <= ZERO_W;
      r_hi_r      <= ZERO_W;
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
      div0_r      <= 1'b0;
      op_r        <= 4'b0000;
      a_r         <= ZERO_W;
      b_r         <= ZERO_W;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r       <= op;
            a_r        <= a;
            b_r        <= b;
            in_ready_r <= 1'b0;
            state_r    <= iter_op_s ? BUSY : EXEC;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        EXEC: begin
          r_r         <= res_s;
          r_hi_r      <= res_hi_s;
          zero_r      <= zero_s;
          ovf_r       <= ovf_s;
          div0_r      <= div0_s;
          out_valid_r <= 1'b1;
          state_r     <= DONE;
        end
        BUSY: begin
          if (mdu_done_s) begin
            r_r         <= mdu_lo_s;
            r_hi_r      <= mdu_hi_s;
            zero_r      <= (mdu_lo_s == ZERO_W);
            ovf_r       <= 1'b0;
            div0_r      <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= BUSY;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            r_r         <= ZERO_W;
            r_hi_r      <= ZERO_W;
            zero_r      <= 1'b0;
            ovf_r       <= 1'b0;
            div0_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r    <= IDLE;
          in_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign r         = r_r;
  assign r_hi      = r_hi_r;
  assign zero      = zero_r;
  assign ovf       = ovf_r;
  assign div0      = div0_r;

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: random and directed ops checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_mdu;

  localparam int W = 32;
  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] r;
  logic [W-1:0] r_hi;
  logic         zero;
  logic         ovf;
  logic         div0;

  alu_mdu #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .r_hi(r_hi), .zero(zero), .ovf(ovf), .div0(div0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] hi;
    logic         zero;
    logic         ovf;
    logic         div0;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   seen = 1'b0;
  bit   first_hold = 1'b1;
  int   hold = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint sx, sy, t;
    logic [63:0] p;
    bit     rsvd, div_en;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.r = '0; e.hi = '0; e.ovf = 1'b0; e.div0 = 1'b0; e.lat = 1; e.acc_cyc = 0;
    rsvd = 1'b0;
`ifdef ALU_MDU_DIV_EN
    div_en = 1'b1;
`else
    div_en = 1'b0;
`endif
    case (o)
      4'd0:  e.r = x & y;
      4'd1:  e.r = x | y;
      4'd2:  begin t = sx + sy; e.r = x + y; e.ovf = (t > SMAX) || (t < SMIN); end
      4'd3:  e.r = x ^ y;
      4'd4:  e.r = (x < y) ? 32'd1 : 32'd0;
      4'd5:  e.r = x << y[4:0];
      4'd6:  begin t = sx - sy; e.r = x - y; e.ovf = (t > SMAX) || (t < SMIN); end
      4'd7:  e.r = (sx < sy) ? 32'd1 : 32'd0;
      4'd8:  e.r = x >> y[4:0];
      4'd9:  begin t = sx >>> y[4:0]; e.r = t[31:0]; end
      4'd12: e.r = ~(x | y);
      4'd10: begin p = {32'd0, x} * {32'd0, y}; e.r = p[31:0]; e.hi = p[63:32]; e.lat = W + 1; end
      4'd11: begin t = sx * sy; e.r = t[31:0]; e.hi = t[63:32]; e.lat = W + 1; end
      4'd13, 4'd14: begin
        if (!div_en) begin
          e.div0 = 1'b1;
        end else if (y == 32'd0) begin
          e.r = 32'hFFFF_FFFF; e.hi = x; e.div0 = 1'b1;
        end else if (o == 4'd13) begin
          e.r = x / y; e.hi = x % y; e.lat = W + 1;
        end else begin
          t = sx / sy; e.r = t[31:0];
          t = sx % sy; e.hi = t[31:0];
          e.lat = W + 1;
        end
      end
      default: rsvd = 1'b1;
    endcase
    e.zero = !rsvd && (e.r == 32'd0);
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Driver: called at a falling edge; offers one op, then scrambles the inputs after accept.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   t;
    bit   stall_bad;
    t = 0;
    stall_bad = 1'b0;
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (!in_ready) begin
      chk("in_ready_timeout", 128'(in_ready), 128'(1));
      return;
    end
    e = model(o, x, y);
    e.acc_cyc = cyc + 1;
    sb_q.push_back(e);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    in_valid = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
    t = 0;
    while (!out_valid && t < 60) begin
      if (in_ready) stall_bad = 1'b1;
      @(negedge clk);
      t++;
    end
    chk("in_ready_low_while_busy", 128'(stall_bad), 128'(0));
  endtask

  // Monitor: compares the head of the scoreboard whenever a result is presented, with random back-pressure.
  always @(negedge clk) begin
    if (!mon_en) begin
      out_ready = 1'b0;
    end else if (out_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_out_valid", 128'(sb_q.size()), 128'(1));
        out_ready = 1'b1;
      end else begin
        if (!seen) begin
          seen = 1'b1;
          chk("latency", 128'(cyc - sb_q[0].acc_cyc), 128'(sb_q[0].lat));
          hold = first_hold ? 5 : int'($urandom_range(0, 3));
          first_hold = 1'b0;
        end
        chk("result", 128'({r, r_hi, zero, ovf, div0}),
            128'({sb_q[0].r, sb_q[0].hi, sb_q[0].zero, sb_q[0].ovf, sb_q[0].div0}));
        chk("in_ready_low_while_valid", 128'(in_ready), 128'(0));
        if (hold > 0) begin
          hold--;
          out_ready = 1'b0;
        end else begin
          out_ready = 1'b1;
          void'(sb_q.pop_front());
          seen = 1'b0;
        end
      end
    end else begin
      chk("flags_idle", 128'({zero, ovf, div0}), 128'(0));
      out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached with %0d results outstanding", sb_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 128'({out_valid, in_ready, r, r_hi, zero, ovf, div0}), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", 128'(in_ready), 128'(1));

    // Abort a divide in flight with reset.
    in_valid = 1'b1; op = 4'd14; a = 32'd100; b = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_abort_outputs", 128'({out_valid, in_ready, r, r_hi, zero, ovf, div0}), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_abort", 128'(in_ready), 128'(1));

    mon_en = 1'b1;
    issue(4'd14, 32'd100, 32'd7);
    issue(4'd2,  32'h7FFF_FFFF, 32'd1);
    issue(4'd6,  32'd5, 32'd5);
    issue(4'd7,  32'hFFFF_FFFF, 32'd1);
    issue(4'd4,  32'hFFFF_FFFF, 32'd1);
    issue(4'd9,  32'h8000_0000, 32'd4);
    issue(4'd11, 32'hFFFF_FFFE, 32'd3);
    issue(4'd14, 32'hFFFF_FFF9, 32'd2);
    issue(4'd13, 32'h1234_5678, 32'd0);
    issue(4'd14, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(4'd15, 32'h1234_5678, 32'h9ABC_DEF0);
    for (int i = 0; i < 200; i++) begin
      issue(4'($urandom_range(0, 15)), pick(), pick());
    end

    t = 0;
    while (sb_q.size() != 0 && t < 500) begin @(negedge clk); t++; end
    chk("scoreboard_drained", 128'(sb_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
